// File: rtl/weight_fifo_row_reader_if.sv
// weight_fifo_row_reader_if: write, load-request and row-stream signals of the weight row reader
interface weight_fifo_row_reader_if #(
  parameter int WEIGHT_BW   = 8,
  parameter int NUM_PE_ROWS = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int FIFO_DEPTH  = 4
);
  localparam int RW = WEIGHT_BW * MATRIX_SIZE;
  localparam int MW = RW * NUM_PE_ROWS;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = NUM_PE_ROWS > 1 ? $clog2(NUM_PE_ROWS) : 1;
  logic          fifo_wr_en;
  logic [MW-1:0] fifo_data_in;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          wr_overflow;
  logic          load_req;
  logic          load_busy;
  logic [RW-1:0] weight_row_out;
  logic          weight_row_valid;
  logic [IW-1:0] weight_row_idx;
  logic          load_done;
  modport master (
    output fifo_wr_en, fifo_data_in, load_req,
    input  fifo_full, fifo_empty, fifo_count, wr_overflow, load_busy,
           weight_row_out, weight_row_valid, weight_row_idx, load_done
  );
  modport slave (
    input  fifo_wr_en, fifo_data_in, load_req,
    output fifo_full, fifo_empty, fifo_count, wr_overflow, load_busy,
           weight_row_out, weight_row_valid, weight_row_idx, load_done
  );
endinterface

// File: rtl/weight_fifo_row_reader.sv
// weight_fifo_row_reader: matrix FIFO that streams the head matrix out as row slices, last row first
module weight_fifo_row_reader #(
  parameter int WEIGHT_BW   = 8,
  parameter int NUM_PE_ROWS = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input logic clk,
  input logic rst_n,
  weight_fifo_row_reader_if.slave bus
);
  localparam int RW = WEIGHT_BW * MATRIX_SIZE;
  localparam int MW = RW * NUM_PE_ROWS;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = NUM_PE_ROWS > 1 ? $clog2(NUM_PE_ROWS) : 1;
  typedef enum logic {IDLE, LOAD} state_t;
  state_t        state;
  logic [MW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] cnt;
  logic          push, pop, start, busy;
  logic [CW-1:0] count_nx;
  logic [MW-1:0] head;
  always_comb begin
    push     = bus.fifo_wr_en && !bus.fifo_full;
    pop      = bus.load_done;
    start    = state == IDLE && bus.load_req && bus.fifo_count > CW'(pop);
    count_nx = bus.fifo_count + CW'(push) - CW'(pop);
    head     = mem[rd_ptr];
    busy     = state == LOAD;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.fifo_data_in;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= IDLE;
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      cnt                  <= '0;
      bus.fifo_count       <= '0;
      bus.fifo_full        <= 1'b0;
      bus.fifo_empty       <= 1'b1;
      bus.wr_overflow      <= 1'b0;
      bus.load_busy        <= 1'b0;
      bus.weight_row_out   <= '0;
      bus.weight_row_valid <= 1'b0;
      bus.weight_row_idx   <= '0;
      bus.load_done        <= 1'b0;
    end else begin
      wr_ptr               <= push ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr               <= pop ? rd_ptr + PW'(1) : rd_ptr;
      bus.fifo_count       <= count_nx;
      bus.fifo_full        <= count_nx == CW'(FIFO_DEPTH);
      bus.fifo_empty       <= count_nx == '0;
      bus.wr_overflow      <= bus.fifo_wr_en && bus.fifo_full;
      state                <= busy ? (cnt == '0 ? IDLE : LOAD) : (start ? LOAD : IDLE);
      cnt                  <= busy ? cnt - IW'(1) : IW'(NUM_PE_ROWS - 1);
      bus.load_busy        <= busy;
      bus.weight_row_valid <= busy;
      bus.weight_row_out   <= busy ? head[int'(cnt)*RW +: RW] : '0;
      bus.weight_row_idx   <= busy ? cnt : '0;
      bus.load_done        <= busy && cnt == '0;
    end
  end
endmodule

// File: tb/tb_weight_fifo_row_reader.sv
// tb_weight_fifo_row_reader: randomized scoreboard bench against a timestamped queue model
module tb_weight_fifo_row_reader;
  localparam int WB = 8;
  localparam int N  = 8;
  localparam int MS = 8;
  localparam int D  = 4;
  localparam int RW = WB * MS;
  localparam int MW = RW * N;
  typedef struct {
    int            cyc;
    logic [RW-1:0] row;
    int            idx;
    bit            done;
  } beat_t;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pop_edge = -1;
  int free_edge = 0;
  bit ovf_e = 0;
  logic [MW-1:0] q[$];
  beat_t expq[$];
  weight_fifo_row_reader_if #(.WEIGHT_BW(WB), .NUM_PE_ROWS(N), .MATRIX_SIZE(MS), .FIFO_DEPTH(D)) bus ();
  weight_fifo_row_reader #(.WEIGHT_BW(WB), .NUM_PE_ROWS(N), .MATRIX_SIZE(MS), .FIFO_DEPTH(D)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [MW-1:0] a, input logic [MW-1:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", n, cyc, a, x);
    end
  endtask
  always @(posedge clk) begin
    int e;
    bit do_pop, full;
    logic [MW-1:0] h;
    cyc++;
    e = cyc;
    if (!rst_n) begin
      q.delete();
      expq.delete();
      pop_edge = -1;
      free_edge = 0;
      ovf_e = 0;
    end else begin
      do_pop = e == pop_edge;
      full = q.size() == D;
      ovf_e = bus.fifo_wr_en && full;
      if (bus.load_req && e >= free_edge && q.size() > int'(do_pop)) begin
        h = do_pop ? q[1] : q[0];
        for (int r = N - 1; r >= 0; r--) expq.push_back('{e + N - r, h[r*RW +: RW], r, r == 0});
        pop_edge = e + N + 1;
        free_edge = e + N + 1;
      end
      if (do_pop) void'(q.pop_front());
      if (bus.fifo_wr_en && !full) q.push_back(bus.fifo_data_in);
    end
  end
  always @(negedge clk) begin
    beat_t b;
    chk("count", MW'(bus.fifo_count), MW'(q.size()));
    chk("full", MW'(bus.fifo_full), MW'(q.size() == D));
    chk("empty", MW'(bus.fifo_empty), MW'(q.size() == 0));
    chk("overflow", MW'(bus.wr_overflow), MW'(ovf_e));
    chk("busy", MW'(bus.load_busy), MW'(bus.weight_row_valid));
    if (bus.weight_row_valid) begin
      if (expq.size() == 0 || expq[0].cyc != cyc) chk("unexpected_beat", 1, 0);
      else begin
        b = expq.pop_front();
        chk("row", MW'(bus.weight_row_out), MW'(b.row));
        chk("idx", MW'(bus.weight_row_idx), MW'(b.idx));
        chk("done", MW'(bus.load_done), MW'(b.done));
      end
    end else begin
      chk("row_idle", MW'(bus.weight_row_out), 0);
      chk("idx_idle", MW'(bus.weight_row_idx), 0);
      chk("done_idle", MW'(bus.load_done), 0);
      if (expq.size() != 0 && expq[0].cyc <= cyc) begin
        chk("missing_beat", 0, 1);
        void'(expq.pop_front());
      end
    end
  end
  function automatic logic [MW-1:0] rmat();
    logic [MW-1:0] m;
    for (int i = 0; i < MW / 32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction
  function automatic logic [MW-1:0] fill(input logic [7:0] v);
    return {(MW / 8){v}};
  endfunction
  task automatic step(input bit wr, input logic [MW-1:0] d, input bit req);
    bus.fifo_wr_en = wr;
    bus.fifo_data_in = d;
    bus.load_req = req;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0);
  endtask
  task automatic wait_beat(input bit want_done, input int want_idx);
    int n = 0;
    while (n < 30 && !(want_done ? bus.load_done : (bus.weight_row_valid && int'(bus.weight_row_idx) == want_idx))) begin
      step(0, '0, 0);
      n++;
    end
    chk("wait_bound", MW'(n < 30), 1);
  endtask
  initial begin
    logic [MW-1:0] m;
    bus.fifo_wr_en = 0;
    bus.fifo_data_in = '0;
    bus.load_req = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int r = 0; r < N; r++) m[r*RW +: RW] = {(RW / 8){8'(r + 1)}};
    step(1, m, 0);
    step(0, '0, 1);
    idle(12);
    step(0, '0, 1);
    idle(3);
    step(1, fill(8'hAA), 0);
    step(1, fill(8'hBB), 0);
    step(1, fill(8'hCC), 0);
    step(1, fill(8'hDD), 0);
    step(1, fill(8'hEE), 0);
    idle(2);
    for (int i = 0; i < 4; i++) begin
      step(0, '0, 1);
      idle(10);
    end
    step(1, rmat(), 0);
    step(1, rmat(), 0);
    for (int i = 0; i < 30; i++) step(0, '0, 1);
    idle(5);
    for (int i = 0; i < D; i++) step(1, rmat(), 0);
    step(0, '0, 1);
    wait_beat(1, 0);
    step(1, rmat(), 0);
    idle(3);
    for (int i = 0; i < 10; i++) begin
      step(1, rmat(), 1);
      idle(10);
    end
    for (int i = 0; i < 600; i++) step($urandom_range(0, 2) == 0, rmat(), $urandom_range(0, 3) == 0);
    idle(40);
    step(1, rmat(), 0);
    step(0, '0, 1);
    wait_beat(0, 4);
    rst_n = 0;
    step(0, '0, 0);
    rst_n = 1;
    idle(3);
    step(1, rmat(), 1);
    step(0, '0, 1);
    idle(15);
    chk("drained", MW'(expq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/weight_fifo_row_reader.md
Name: weight_fifo_row_reader

Overview:
Read-side counterpart of the weight-FIFO data source. Buffers whole weight matrices presented as one flat bus (WEIGHT_BW*NUM_PE_ROWS*MATRIX_SIZE bits). On request, streams one matrix out as NUM_PE_ROWS row slices, one per cycle, into the systolic array's weight-preload chain. Sits between the weight source and the PE array top row.

Parameters:
WEIGHT_BW, 8, bits per weight element
NUM_PE_ROWS, 8, rows per matrix entry; also the number of row beats per load
MATRIX_SIZE, 8, weights per row (PE columns)
FIFO_DEPTH, 4, matrix entries stored; power of 2, >=2

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous, active-low reset
fifo_wr_en  in  1  push fifo_data_in this cycle
fifo_data_in  in  WEIGHT_BW*NUM_PE_ROWS*MATRIX_SIZE  matrix; row r = bits [(r+1)*WEIGHT_BW*MATRIX_SIZE-1 : r*WEIGHT_BW*MATRIX_SIZE]
fifo_full  out  1  count==FIFO_DEPTH
fifo_empty  out  1  count==0
fifo_count  out  $clog2(FIFO_DEPTH+1)  stored entries
wr_overflow  out  1  1-cycle pulse: write dropped because full
load_req  in  1  request streaming of the head entry
load_busy  out  1  high while in LOAD
weight_row_out  out  WEIGHT_BW*MATRIX_SIZE  current row slice
weight_row_valid  out  1  weight_row_out valid
weight_row_idx  out  max(1,$clog2(NUM_PE_ROWS))  row index of weight_row_out
load_done  out  1  1-cycle pulse, coincident with last row beat

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. All state updates on the rising edge of clk.
- Reset (rst_n=0 at an edge):
  - Pointers and count cleared; FSM to IDLE.
  - All outputs 0, except fifo_empty=1.
  - Reset mid-LOAD aborts the stream immediately. The FIFO contents are discarded.
- Storage: register array of FIFO_DEPTH entries; wr_ptr/rd_ptr wrap modulo FIFO_DEPTH.
- Write:
  - fifo_wr_en=1 with registered fifo_full=0: store at wr_ptr, wr_ptr+1.
  - fifo_wr_en=1 with fifo_full=1: data dropped, no state change, wr_overflow=1 next cycle.
  - Fullness is judged on registered state only. A pop in the same cycle does not rescue a write made while full.
- FSM states: IDLE, LOAD.
  - IDLE -> LOAD when load_req=1 and registered fifo_empty=0; row counter set to NUM_PE_ROWS-1.
  - load_req while empty, or while in LOAD, is ignored (no queuing, no error).
  - A write into an empty FIFO in the same cycle as load_req does not satisfy that request.
- LOAD:
  - Each cycle, registered outputs present weight_row_out = row[counter] of the head entry, weight_row_valid=1, weight_row_idx=counter, load_busy=1.
  - Counter decrements each cycle. Order is row NUM_PE_ROWS-1 first, row 0 last, so row 0 lands in the top PE row after the shift.
- Latency: load_req sampled at edge T gives the first beat visible after edge T+1 and the last beat after edge T+NUM_PE_ROWS. Beats are back-to-back with no gaps.
- Last beat (counter==0):
  - load_done=1 in the same cycle.
  - At the end of that cycle: head entry popped (rd_ptr+1, count-1) and FSM -> IDLE.
  - weight_row_valid, load_busy and load_done return to 0. weight_row_out returns to 0 (outputs zeroed when not valid).
- Back-to-back loads: earliest new load_req is sampled at the edge after load_done, giving one idle cycle between matrices.
- Head entry is stable throughout LOAD; writes to other slots never disturb the streaming entry.
- Simultaneous write and pop: count unchanged; both pointers advance.
- fifo_full, fifo_empty and fifo_count are registered and consistent with each other every cycle.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> fifo_empty=1, fifo_count=0, all other outputs 0.
- Single load: write matrix with every byte of row r = r+1 (default params), then assert load_req 1 cycle -> 8 consecutive beats idx 7..0, each weight_row_out = 8 bytes of 0x08..0x01 in turn. load_done appears on the idx-0 beat; fifo_count goes 1->0 afterwards.
- Fill/overflow: 5 consecutive writes with data 0xAA.., 0xBB.., 0xCC.., 0xDD.., 0xEE.. -> fifo_full after the 4th write, wr_overflow pulses once. Four subsequent loads stream AA, BB, CC, DD in order; EE never appears.
- Empty and busy requests: load_req while empty -> no valid beats. load_req held high during LOAD -> exactly 8 beats, then one idle cycle, then the next matrix streams if present.
- Wrap and concurrency: with count=4, write an entry on the cycle load_done pulses -> write dropped (full judged on registered state), count=3. Repeat 10 write/load cycles across the pointer wrap -> data order preserved.
- Reset mid-load: drop rst_n at beat idx 4 -> next cycle weight_row_valid=0, load_busy=0, fifo_empty=1, fifo_count=0.
